sram_like_slave: RTL and testbench

Responder end of the CPU's SRAM-like memory interface: accepts address-phase requests (`req`/`addr_ok`) from the CPU core and returns data-phase responses (`data_ok`/`rdata`) after a fixed, parameterised latency. It holds a word-addressed memory array and queues up to `MAX_OUTSTANDING` accepted requests, answering strictly in order. It serves as the simulation-side instruction or data memory for the multi-cycle and pipelined cores, replacing the zero-latency synchronous SRAM.

---
 rtl/sram_like_if.sv | 23 ++
 rtl/sram_like_slave.sv | 102 ++++++++++
 tb/tb_sram_like_slave.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/sram_like_if.sv
// SRAM-like bus between a CPU core (master) and a memory responder (slave):
// address phase req/addr_ok, data phase data_ok/rdata.
interface sram_like_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_slave.sv
// Fixed-latency SRAM-like responder: word memory plus an in-order queue of
// accepted requests, each answered once its countdown reaches zero.
module sram_like_slave #(
    parameter int DEPTH_LOG2      = 10,
    parameter int LATENCY         = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic         clk,
    input  logic         reset,
    sram_like_if.slave   bus
);
    localparam int         WORDS   = 1 << DEPTH_LOG2;
    localparam int         PTR_W   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int         CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [3:0] CD_INIT = 4'(LATENCY - 1);

    logic [31:0]      mem [WORDS];
    logic [31:0]      q_data_q  [MAX_OUTSTANDING];
    logic             q_wr_q    [MAX_OUTSTANDING];
    logic             q_wr_d    [MAX_OUTSTANDING];
    logic             q_valid_q [MAX_OUTSTANDING];
    logic             q_valid_d [MAX_OUTSTANDING];
    logic [3:0]       q_cd_q    [MAX_OUTSTANDING];
    logic [3:0]       q_cd_d    [MAX_OUTSTANDING];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic                  push;
    logic                  pop;
    logic                  data_ok;
    logic [DEPTH_LOG2-1:0] widx;
    logic                  unused_bits;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Address bits outside the word index alias onto the same word.
    assign widx        = bus.addr[DEPTH_LOG2+1:2];
    assign unused_bits = ^{bus.addr[31:DEPTH_LOG2+2], bus.addr[1:0], bus.size};

    assign bus.addr_ok = !reset && (count_q < CNT_W'(MAX_OUTSTANDING));
    assign push        = bus.req && bus.addr_ok;
    assign data_ok     = (count_q != '0) && q_valid_q[head_q] && (q_cd_q[head_q] == 4'd0);
    assign pop         = data_ok;
    assign bus.data_ok = data_ok;
    assign bus.rdata   = (data_ok && !q_wr_q[head_q]) ? q_data_q[head_q] : '0;

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        q_valid_d = q_valid_q;
        q_cd_d    = q_cd_q;
        q_wr_d    = q_wr_q;
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (q_valid_q[i] && q_cd_q[i] != 4'd0)
                q_cd_d[i] = q_cd_q[i] - 4'd1;
        end
        if (pop) begin
            q_valid_d[head_q] = 1'b0;
            head_d            = ptr_inc(head_q);
        end
        // Push only happens when not full, so the tail slot is never the one popping.
        if (push) begin
            q_valid_d[tail_q] = 1'b1;
            q_cd_d[tail_q]    = CD_INIT;
            q_wr_d[tail_q]    = bus.wr;
            tail_d            = ptr_inc(tail_q);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++)
                q_valid_q[i] <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            q_valid_q <= q_valid_d;
        end
        q_cd_q <= q_cd_d;
        q_wr_q <= q_wr_d;
    end

    // Memory is never reset; a read captures the pre-edge word into its queue slot.
    always_ff @(posedge clk) begin
        if (push && bus.wr) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.wstrb[b])
                    mem[widx][b*8 +: 8] <= bus.wdata[b*8 +: 8];
            end
        end
        if (push)
            q_data_q[tail_q] <= mem[widx];
    end
endmodule

// File: tb/tb_sram_like_slave.sv
// Bench for sram_like_slave: three instances (latency 2, 4, 1) sharing clk/reset,
// each with a model memory and an in-order scoreboard of expected responses.
module tb_sram_like_slave;
    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    int          cyc = 0;
    int          tests_run = 0;
    int          tests_failed = 0;

    logic        req_s   [3];
    logic        wr_s    [3];
    logic [3:0]  wstrb_s [3];
    logic [31:0] addr_s  [3];
    logic [31:0] wdata_s [3];
    logic        aok_s   [3];
    logic        dok_s   [3];
    logic [31:0] rdata_s [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
        localparam int LAT = (gi == 0) ? 2 : ((gi == 1) ? 4 : 1);

        sram_like_if bus();

        sram_like_slave #(
            .DEPTH_LOG2(10),
            .LATENCY(LAT),
            .MAX_OUTSTANDING(2)
        ) u_dut (
            .clk(clk),
            .reset(reset),
            .bus(bus)
        );

        assign bus.req     = req_s[gi];
        assign bus.wr      = wr_s[gi];
        assign bus.size    = 2'd2;
        assign bus.wstrb   = wstrb_s[gi];
        assign bus.addr    = addr_s[gi];
        assign bus.wdata   = wdata_s[gi];
        assign aok_s[gi]   = bus.addr_ok;
        assign dok_s[gi]   = bus.data_ok;
        assign rdata_s[gi] = bus.rdata;

        exp_t        sb [$];
        logic [31:0] mdl [1024];

        initial begin
            for (int w = 0; w < 1024; w++) begin
                mdl[w] = (w == 16) ? 32'hDEADBEEF :
                         (w == 32) ? 32'hAAAAAAAA : (32'h5A5A0000 | 32'(w * 7 + gi));
                u_dut.mem[w] = mdl[w];
            end
        end

        always @(negedge clk) begin : mon
            exp_t        e;
            logic [9:0]  idx;
            logic [31:0] nw;
            check($sformatf("i%0d addr_ok", gi), {31'b0, bus.addr_ok},
                  {31'b0, (!reset && sb.size() < 2)});
            if (reset) begin
                sb.delete();
            end else begin
                if (bus.data_ok) begin
                    if (sb.size() == 0) begin
                        check($sformatf("i%0d spurious data_ok", gi), 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        $display("[TB] i%0d cyc %0d data_ok rdata=%h", gi, cyc, bus.rdata);
                        check($sformatf("i%0d rdata", gi), bus.rdata, e.data);
                        check($sformatf("i%0d resp cycle", gi), 32'(cyc), 32'(e.cyc));
                    end
                end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                    check($sformatf("i%0d missing data_ok", gi), 32'd0, 32'd1);
                    void'(sb.pop_front());
                end
                // Request is accepted at the coming rising edge.
                if (req_s[gi] && bus.addr_ok) begin
                    idx   = addr_s[gi][11:2];
                    e.cyc = cyc + LAT;
                    if (wr_s[gi]) begin
                        nw = mdl[idx];
                        for (int b = 0; b < 4; b++)
                            if (wstrb_s[gi][b]) nw[b*8 +: 8] = wdata_s[gi][b*8 +: 8];
                        mdl[idx] = nw;
                        e.data   = 32'd0;
                    end else begin
                        e.data = mdl[idx];
                    end
                    sb.push_back(e);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds the request until accepted, returning just after the accepting edge.
    task automatic issue(input int j, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        bit ok;
        int n;
        req_s[j] = 1'b1; wr_s[j] = w; addr_s[j] = a; wdata_s[j] = d; wstrb_s[j] = s;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = aok_s[j];
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) check("accept timeout", 32'd0, 32'd1);
        req_s[j] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        for (int j = 0; j < 3; j++) begin
            req_s[j] = 1'b0; wr_s[j] = 1'b0; wstrb_s[j] = 4'h0;
            addr_s[j] = 32'h0; wdata_s[j] = 32'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            check($sformatf("i%0d reset data_ok", j), {31'b0, dok_s[j]}, 32'd0);
            check($sformatf("i%0d reset rdata", j), rdata_s[j], 32'd0);
        end
        @(posedge clk);
        #1 reset = 1'b0;

        // Latency-2 read of preloaded word 0x10
        issue(0, 1'b0, 32'h0000_0040, 32'h0, 4'h0);
        idle(6);

        // Byte-masked write then read of the same word
        issue(0, 1'b1, 32'h0000_0080, 32'h1122_3344, 4'b0101);
        issue(0, 1'b0, 32'h0000_0080, 32'h0, 4'h0);
        idle(6);
        check("i0 masked write word", g_inst[0].u_dut.mem[32], 32'hAA22AA44);

        // Zero-strobe write leaves the word unchanged
        issue(0, 1'b1, 32'h0000_0084, 32'hFFFF_FFFF, 4'b0000);
        issue(0, 1'b0, 32'h0000_0084, 32'h0, 4'h0);
        idle(6);

        // High address bits alias onto word 0x10
        issue(0, 1'b0, 32'h1000_0040, 32'h0, 4'h0);
        idle(6);

        // Latency 4 with two outstanding: third request stalls until a pop
        issue(1, 1'b0, 32'h0000_0000, 32'h0, 4'h0);
        issue(1, 1'b0, 32'h0000_0004, 32'h0, 4'h0);
        issue(1, 1'b0, 32'h0000_0008, 32'h0, 4'h0);
        idle(10);

        // Latency 1, a read every cycle
        for (int k = 0; k < 8; k++)
            issue(2, 1'b0, 32'(k * 4), 32'h0, 4'h0);
        idle(5);

        // Reset with two reads outstanding drops them
        issue(1, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
        issue(1, 1'b0, 32'h0000_0014, 32'h0, 4'h0);
        reset = 1'b1;
        @(negedge clk);
        check("i1 addr_ok in reset", {31'b0, aok_s[1]}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("i1 addr_ok after reset", {31'b0, aok_s[1]}, 32'd1);
        idle(10);

        // Earlier write survives reset
        issue(0, 1'b0, 32'h0000_0080, 32'h0, 4'h0);
        idle(6);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
